// File: rtl/mixer_sched_pkg.sv
// Shared types and helpers for the mixer scheduler: id width function and the
// tagged-result record carried between the pipeline and its consumers.
`ifndef FIXDT_64_A_WIDTH
`define FIXDT_64_A_WIDTH 64
`endif
`ifndef FIXDT_64_A_FRAC_WIDTH
`define FIXDT_64_A_FRAC_WIDTH 43
`endif

package mixer_sched_pkg;

    localparam int MAX_ID_W       = 4;
    localparam int DEF_DATA_WIDTH = `FIXDT_64_A_WIDTH;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [MAX_ID_W-1:0]       id;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      overflow;
        logic                      underflow;
    } mixer_rsp_t;

endpackage

// File: rtl/mixer_sched_if.sv
// Request/response bundle between the demodulator channels and mixer_sched.
// master = channel side, slave = scheduler side.
interface mixer_sched_if
    import mixer_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `FIXDT_64_A_WIDTH
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic                               rsp_overflow;
    logic                               rsp_underflow;
    logic [NUM_REQ-1:0]                 sat_sticky;
    logic [NUM_REQ-1:0]                 sat_clear;
    logic                               busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready, sat_clear,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_overflow,
               rsp_underflow, sat_sticky, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, sat_clear,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_overflow,
               rsp_underflow, sat_sticky, busy
    );

endinterface

// File: rtl/mixer.sv
// Fixed-point signed saturating multiplier: full product, arithmetic shift by
// the fractional width, clamp to the representable range with direction flags.
module mixer #(
    parameter int DATA_WIDTH      = `FIXDT_64_A_WIDTH,
    parameter int DATA_FRAC_WIDTH = `FIXDT_64_A_FRAC_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] product,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] shifted;

    assign a_ext   = a;
    assign b_ext   = b;
    assign shifted = (a_ext * b_ext) >>> DATA_FRAC_WIDTH;

    // In range only when every bit above the result MSB matches the sign.
    assign overflow  = !shifted[PW-1] &&  (|shifted[PW-2:DATA_WIDTH-1]);
    assign underflow =  shifted[PW-1] && !(&shifted[PW-2:DATA_WIDTH-1]);

    always_comb begin
        if (overflow)
            product = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (underflow)
            product = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            product = shifted[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/mixer_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr (wrapping)
// and moves rr_ptr just past the winner whenever a grant is taken.
module rr_arbiter
    import mixer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] idx;
    logic            found;
    int              sum;

    always_comb begin
        // NOTE: every variable gets a default before the search loop, so no
        // path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        sum       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = int'(rr_ptr) + off;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            idx = ID_W'(sum);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (enable && (|req)) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

endmodule

// File: rtl/mixer_sched.sv
// Time-shares one mixer among NUM_REQ requesters: round-robin grant, operand
// register, result register with id tag, and per-requester sticky saturation.
module mixer_sched
    import mixer_sched_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_WIDTH      = `FIXDT_64_A_WIDTH,
    parameter int DATA_FRAC_WIDTH = `FIXDT_64_A_FRAC_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    mixer_sched_if.slave  bus
);

    localparam int ID_W = id_width(NUM_REQ);

    typedef struct packed {
        logic                  valid;
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } stage1_t;

    typedef struct packed {
        logic                  valid;
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] data;
        logic                  overflow;
        logic                  underflow;
    } stage2_t;

    stage1_t               s1;
    stage2_t               s2;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]    sat_set;
    logic [NUM_REQ-1:0]    sat_sticky;
    logic                  advance;
    logic                  s1_load_ok;
    logic                  arb_enable;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] mix_product;
    logic                  mix_overflow;
    logic                  mix_underflow;

    assign advance    = s1.valid & (~s2.valid | bus.rsp_ready);
    assign s1_load_ok = ~s1.valid | advance;
    // Gating with rst_n keeps req_ready low for the whole reset, even though
    // the pipeline registers already read empty.
    assign arb_enable = s1_load_ok & rst_n;
    assign handshake  = arb_enable & (|bus.req_valid);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    mixer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DATA_FRAC_WIDTH (DATA_FRAC_WIDTH)
    ) u_mixer (
        .a         (s1.a),
        .b         (s1.b),
        .product   (mix_product),
        .overflow  (mix_overflow),
        .underflow (mix_underflow)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its sources. Data fields are reset along with the
    // valids because they drive outputs that must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (handshake) begin
            s1 <= '{valid: 1'b1, id: grant_idx,
                    a: bus.req_a[grant_idx], b: bus.req_b[grant_idx]};
        end else if (advance) begin
            s1.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2 <= '0;
        end else if (advance) begin
            s2 <= '{valid: 1'b1, id: s1.id, data: mix_product,
                    overflow: mix_overflow, underflow: mix_underflow};
        end else if (bus.rsp_ready) begin
            s2.valid <= 1'b0;
        end
    end

    always_comb begin
        sat_set = '0;
        if (advance && (mix_overflow || mix_underflow))
            sat_set[s1.id] = 1'b1;
    end

    // Set is OR-ed after the clear so a coincident set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_sticky <= '0;
        else
            sat_sticky <= (sat_sticky & ~bus.sat_clear) | sat_set;
    end

    assign bus.req_ready     = grant & {NUM_REQ{arb_enable}};
    assign bus.rsp_valid     = s2.valid;
    assign bus.rsp_id        = s2.id;
    assign bus.rsp_data      = s2.data;
    assign bus.rsp_overflow  = s2.overflow;
    assign bus.rsp_underflow = s2.underflow;
    assign bus.sat_sticky    = sat_sticky;
    assign bus.busy          = s1.valid | s2.valid;

endmodule

// File: tb/tb_mixer_sched.sv
// Self-checking bench for mixer_sched: directed cases with literal expectations
// plus randomized traffic compared every cycle against a queue-based model.
module tb_mixer_sched;
    import mixer_sched_pkg::*;

    localparam int N = 4;
    localparam logic [63:0] ONE     = 64'sh0000080000000000;
    localparam logic [63:0] TWO     = 64'sh0000100000000000;
    localparam logic [63:0] MAXV    = 64'sh7fffffffffffffff;
    localparam logic [63:0] MINV    = 64'sh8000000000000000;
    localparam logic [63:0] ONE_EPS = 64'sh0000080000000001;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    mixer_sched_if #(.NUM_REQ(N), .DATA_WIDTH(64)) bus ();

    mixer_sched #(.NUM_REQ(N), .DATA_WIDTH(64), .DATA_FRAC_WIDTH(43)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference product: exact 128-bit product, floor-shift by 43, clamp.
    function automatic mixer_rsp_t model_mul(input int id, input logic [63:0] a, input logic [63:0] b);
        mixer_rsp_t       r;
        logic signed [127:0] wa, wb, full, q, hi, lo;
        wa   = $signed(a);
        wb   = $signed(b);
        full = wa * wb;
        q    = full >>> 43;
        hi   = 128'sh7fffffffffffffff;
        lo   = -hi - 1;
        r.id = 4'(id);
        r.overflow  = 1'b0;
        r.underflow = 1'b0;
        if (q > hi) begin
            r.data = MAXV;
            r.overflow = 1'b1;
        end else if (q < lo) begin
            r.data = MINV;
            r.underflow = 1'b1;
        end else begin
            r.data = q[63:0];
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: return MAXV;
            1: return MINV;
            2: return ONE_EPS;
            3: return v;
            4: return 64'($signed(v) >>> $urandom_range(8, 30));
            default: return 64'($signed(v) >>> 20) + ONE;
        endcase
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        mixer_rsp_t r;
        int         entry;
        bit         shown;
    } item_t;

    item_t      q[$];
    int         ptr = 0;
    logic [N-1:0] sticky_m = '0;
    int         cyc = 0;
    bit         armed = 0;

    initial begin : model
        bit           exp_valid, load_ok, pop;
        int           g;
        logic [N-1:0] exp_ready;
        item_t        it;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                armed = 1;
                q.delete();
                ptr = 0;
                sticky_m = '0;
                check("m_rst_rsp_valid", bus.rsp_valid, 0);
                check("m_rst_req_ready", bus.req_ready, 0);
                check("m_rst_busy", bus.busy, 0);
                check("m_rst_sticky", bus.sat_sticky, 0);
                cyc++;
                continue;
            end
            if (!armed) continue;

            exp_valid = (q.size() > 0) && (q[0].entry < cyc);
            g = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            // Two-deep pipeline: room whenever fewer than two results are
            // in flight, or the presented one leaves at this edge.
            load_ok   = (q.size() < 2) || (bus.rsp_ready && exp_valid);
            exp_ready = (g >= 0 && load_ok) ? N'(1 << g) : '0;

            check("m_req_ready", bus.req_ready, exp_ready);
            check("m_rsp_valid", bus.rsp_valid, exp_valid);
            check("m_busy", bus.busy, q.size() > 0);
            check("m_sticky", bus.sat_sticky, sticky_m);
            if (exp_valid) begin
                check("m_rsp_id", bus.rsp_id, q[0].r.id);
                check("m_rsp_data", bus.rsp_data, q[0].r.data);
                check("m_rsp_ovf", bus.rsp_overflow, q[0].r.overflow);
                check("m_rsp_unf", bus.rsp_underflow, q[0].r.underflow);
            end

            pop = exp_valid && bus.rsp_ready;
            sticky_m = sticky_m & ~bus.sat_clear;
            if (pop) void'(q.pop_front());
            if (exp_ready != '0) begin
                it.r     = model_mul(g, bus.req_a[g], bus.req_b[g]);
                it.entry = cyc + 1;
                it.shown = 0;
                q.push_back(it);
                ptr = (g + 1) % N;
            end
            if (q.size() > 0 && q[0].entry < cyc + 1 && !q[0].shown) begin
                it = q[0];
                it.shown = 1;
                q[0] = it;
                if (it.r.overflow || it.r.underflow) sticky_m[it.r.id] = 1'b1;
            end
            cyc++;
        end
    end

    // ---------------- stimulus + literal expectations ----------------
    initial begin : stim
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        bus.sat_clear = '0;
        #1;
        rst_n = 1'b0;
        bus.req_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_req_ready", bus.req_ready, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_data", bus.rsp_data, 0);
        check("reset_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;

        // 1.0 x 2.0 from requester 0
        @(negedge clk);
        bus.req_a[0] = ONE;
        bus.req_b[0] = TWO;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #4;
        check("basic_valid", bus.rsp_valid, 1);
        check("basic_id", bus.rsp_id, 0);
        check("basic_data", bus.rsp_data, TWO);
        check("basic_flags", {bus.rsp_overflow, bus.rsp_underflow}, 0);

        // overflow on requester 2
        @(negedge clk);
        bus.req_a[2] = MAXV;
        bus.req_b[2] = ONE_EPS;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #4;
        check("ovf_data", bus.rsp_data, MAXV);
        check("ovf_flag", bus.rsp_overflow, 1);
        check("ovf_id", bus.rsp_id, 2);
        check("ovf_sticky2", bus.sat_sticky[2], 1);
        @(negedge clk);
        bus.sat_clear = 4'b0100;
        @(negedge clk);
        bus.sat_clear = '0;
        #4;
        check("clear_sticky2", bus.sat_sticky[2], 0);
        // clear coinciding with a new overflow: set wins
        @(negedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        bus.req_valid = '0;
        bus.sat_clear = 4'b0100;
        @(negedge clk);
        bus.sat_clear = '0;
        #4;
        check("setwins_sticky2", bus.sat_sticky[2], 1);
        check("setwins_ovf", bus.rsp_overflow, 1);

        // underflow on requester 1
        @(negedge clk);
        bus.req_a[1] = MINV;
        bus.req_b[1] = ONE_EPS;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #4;
        check("unf_data", bus.rsp_data, MINV);
        check("unf_flag", bus.rsp_underflow, 1);
        check("unf_sticky", bus.sat_sticky, 4'b0110);

        // fairness from a freshly reset pointer
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.req_a[k] = 64'(k + 1) << 43;
            bus.req_b[k] = ONE;
        end
        bus.req_valid = '1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) bus.req_valid = '0;
            if (i >= 1) begin
                #4;
                check("fair_valid", bus.rsp_valid, 1);
                check("fair_id", bus.rsp_id, (i - 1) % N);
                check("fair_data", bus.rsp_data, 64'(((i - 1) % N) + 1) << 43);
            end
        end

        // backpressure: two handshakes, then everything stalls and holds
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            check("bp_rsp_id", bus.rsp_id, 0);
            check("bp_rsp_data", bus.rsp_data, ONE);
            check("bp_busy", bus.busy, 1);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #4;
        check("bp_resume_ready", bus.req_ready, 4'b0100);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #4;
            check("bp_resume_valid", bus.rsp_valid, 1);
            check("bp_resume_id", bus.rsp_id, (k + 1) % N);
        end

        // reset with both stages full
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid, 0);
        check("midrst_rsp_id", bus.rsp_id, 0);
        check("midrst_rsp_data", bus.rsp_data, 0);
        check("midrst_flags", {bus.rsp_overflow, bus.rsp_underflow}, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        check("midrst_busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #4;
        check("postrst_ready", bus.req_ready, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        #4;
        check("postrst_valid", bus.rsp_valid, 1);
        check("postrst_id", bus.rsp_id, 0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                bus.req_a[k] = rand_operand();
                bus.req_b[k] = rand_operand();
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++)
                bus.sat_clear[k] = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        bus.req_valid = '0;
        bus.sat_clear = '0;
        bus.rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        check("drain_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
